axi4_lite_slv_reg_file: RTL
===========================

Name: axi4_lite_slv_reg_file

Overview:
Parametrised AXI4-Lite slave register file. It exposes N_REGS memory-mapped registers, each of which is read/write (control) or read-only (status, sampled from fabric inputs).
- Address and data channels are accepted independently, in either order or in the same cycle.
- Byte strobes are honoured.
- A per-register write-strobe pulse is provided to user logic.
- Out-of-range and illegal accesses return SLVERR.
- Sits between the AXI4-Lite interconnect and peripheral control/status logic.

Parameters:
N_REGS, 8, number of registers (>=1).
AXI4_LITE_DATA_BIT_WIDTH, 32, data bus width (32 or 64).
AXI4_LITE_ADDR_BIT_WIDTH, 8, address bus width; must be >= ADDR_LSB + max(1, clog2(N_REGS)).
RO_MASK, N_REGS'(0), bit i=1 makes register i read-only.
RST_VAL, '0 (N_REGS*DW bits), reset value of RW registers; register i occupies slice [i*DW +: DW].

Derived: ADDR_LSB = clog2(DW/8); IDX_W = max(1, clog2(N_REGS)); register index = addr[ADDR_LSB +: IDX_W].

Ports:
i_clk  in  1  clock
i_async_rst  in  1  asynchronous active-high reset
if_s_axi4_lite  slv_port  -  axi4_lite_if slave port (ADDR_BIT_WIDTH/DATA_BIT_WIDTH must equal parameters; mismatch -> elaboration $error)
i_sts_regs  in  N_REGS*DW  status values returned for read-only registers (slice i)
o_ctrl_regs  out  N_REGS*DW  current RW register contents (slice i; RO slices drive 0)
o_wr_pulse  out  N_REGS  one-cycle pulse, bit i, on each committed write to RW register i

Behaviour:
- One clock. Reset is asynchronous and active-high. All flops clear asynchronously on i_async_rst=1; no synchronous reset.
- Reset values: awready=0, wready=0, bvalid=0, bresp=0, arready=0, rvalid=0, rresp=0, rdata=0, o_wr_pulse=0, o_ctrl_regs=RST_VAL (RO slices 0). After reset release, awready/wready/arready rise on the first clock edge.
- All AXI outputs are registered.
- Write FSM states: W_IDLE, W_HAVE_ADDR, W_HAVE_DATA, W_COMMIT, W_RESP.
  - W_IDLE: awready=1, wready=1.
  - AW and W handshake in the same cycle -> W_COMMIT.
  - AW handshake only -> latch awaddr, go to W_HAVE_ADDR (awready=0, wready=1).
  - W handshake only -> latch wdata/wstrb, go to W_HAVE_DATA (wready=0, awready=1).
  - Remaining handshake -> W_COMMIT.
  - W_COMMIT (1 cycle): target index legal and RW -> update bytes with wstrb=1, pulse o_wr_pulse[idx], bresp=OKAY. Index >= N_REGS, or RO target -> no update, no pulse, bresp=SLVERR. bvalid=1 next cycle, go to W_RESP.
  - W_RESP: hold bvalid/bresp until bready=1; then bvalid=0 and go to W_IDLE; ready signals reassert the cycle after.
- Latency: minimum 2 cycles from same-cycle AW+W handshake to bvalid. One outstanding write maximum.
- wstrb=0 on an RW register -> no data change, OKAY, pulse still asserted.
- Read FSM states: R_IDLE (arready=1), R_RESP.
  - On AR handshake, capture rdata at the same edge: RW -> stored value; RO -> i_sts_regs slice; out of range -> 0.
  - rresp is OKAY for valid index, SLVERR for out of range.
  - rvalid=1 and arready=0 in the next cycle. Hold rdata/rresp until rready=1, then back to R_IDLE.
  - Latency: 1 cycle from AR handshake to rvalid.
- Read and write FSMs are independent. If a read and a write to the same register resolve in the same cycle, the read returns the pre-write value.
- Address bits below ADDR_LSB and above the index field are ignored.
- Reset asserted mid-transaction aborts it: outputs return to reset values immediately (asynchronously), with no pulse and no response.

Test Plan:
- Reset, then write 0xDEADBEEF to 0x04 with AW and W in the same cycle, wstrb=0xF -> bvalid 2 cycles after handshake, bresp=OKAY, o_ctrl_regs[63:32]=0xDEADBEEF, o_wr_pulse=8'h02 for 1 cycle; read 0x04 -> rdata=0xDEADBEEF, OKAY.
- AW to 0x08 first, W 3 cycles later with data 0x11223344, wstrb=0x5 over prior value 0xFFFFFFFF -> reg2=0xFF22FF44, OKAY. Repeat with W first, then AW -> same result.
- RO_MASK=8'h80, i_sts_regs slice 7=0xCAFE0001: read 0x1C -> 0xCAFE0001, OKAY. Write 0x1C -> SLVERR, no pulse, slice 7 of o_ctrl_regs remains 0.
- N_REGS=5: read 0x14 -> rdata=0, SLVERR; write 0x18 -> SLVERR, o_ctrl_regs unchanged.
- bready held low 10 cycles -> bvalid held, awready/wready=0 throughout. Concurrent read completes with rvalid 1 cycle after AR handshake.
- Assert i_async_rst between AW and W handshakes -> outputs immediately at reset values, no register update. Next full write completes normally.

Source files
------------

// File: rtl/axi4_lite_slv_reg_file_if.sv
// rtl/axi4_lite_slv_reg_file_if.sv - AXI4-Lite bus bundle with slave and master views
interface axi4_lite_if #(
    parameter int ADDR_BIT_WIDTH = 8,
    parameter int DATA_BIT_WIDTH = 32
);
    logic [ADDR_BIT_WIDTH-1:0]   awaddr;
    logic                        awvalid;
    logic                        awready;
    logic [DATA_BIT_WIDTH-1:0]   wdata;
    logic [DATA_BIT_WIDTH/8-1:0] wstrb;
    logic                        wvalid;
    logic                        wready;
    logic [1:0]                  bresp;
    logic                        bvalid;
    logic                        bready;
    logic [ADDR_BIT_WIDTH-1:0]   araddr;
    logic                        arvalid;
    logic                        arready;
    logic [DATA_BIT_WIDTH-1:0]   rdata;
    logic [1:0]                  rresp;
    logic                        rvalid;
    logic                        rready;

    modport slv_port (
        input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport mst_port (
        output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/axi4_lite_slv_reg_file.sv
// rtl/axi4_lite_slv_reg_file.sv - AXI4-Lite slave register file with RW control and RO status registers
module axi4_lite_slv_reg_file #(
    parameter int                                          N_REGS                   = 8,
    parameter int                                          AXI4_LITE_DATA_BIT_WIDTH = 32,
    parameter int                                          AXI4_LITE_ADDR_BIT_WIDTH = 8,
    parameter logic [N_REGS-1:0]                           RO_MASK                  = '0,
    parameter logic [N_REGS*AXI4_LITE_DATA_BIT_WIDTH-1:0]  RST_VAL                  = '0
) (
    input  logic                                          i_clk,
    input  logic                                          i_async_rst,
    axi4_lite_if.slv_port                                 if_s_axi4_lite,
    input  logic [N_REGS*AXI4_LITE_DATA_BIT_WIDTH-1:0]    i_sts_regs,
    output logic [N_REGS*AXI4_LITE_DATA_BIT_WIDTH-1:0]    o_ctrl_regs,
    output logic [N_REGS-1:0]                             o_wr_pulse
);
    localparam int DW       = AXI4_LITE_DATA_BIT_WIDTH;
    localparam int AW       = AXI4_LITE_ADDR_BIT_WIDTH;
    localparam int NB       = DW / 8;
    localparam int ADDR_LSB = $clog2(NB);
    localparam int IDX_W    = (N_REGS > 1) ? $clog2(N_REGS) : 1;
    localparam int N_SLOTS  = 2 ** IDX_W;

    // Index-decodable slots beyond N_REGS are mapped as "absent" so any index is safe to look up.
    localparam logic [N_SLOTS-1:0] RO_EXT    = N_SLOTS'(RO_MASK);
    localparam logic [N_SLOTS-1:0] VALID_EXT = N_SLOTS'({N_REGS{1'b1}});

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    if ($bits(if_s_axi4_lite.wdata) != DW || $bits(if_s_axi4_lite.awaddr) != AW
        || (DW != 32 && DW != 64) || AW < ADDR_LSB + IDX_W) begin : g_param_check
        $error("axi4_lite_slv_reg_file: interface widths do not match parameters");
    end

    typedef enum logic [2:0] {W_IDLE, W_HAVE_ADDR, W_HAVE_DATA, W_COMMIT, W_RESP} w_state_t;
    typedef enum logic {R_IDLE, R_RESP} r_state_t;

    w_state_t          w_state_q, w_state_d;
    r_state_t          r_state_q, r_state_d;
    logic              awready_q, wready_q, bvalid_q, arready_q, rvalid_q;
    logic [1:0]        bresp_q, bresp_d, rresp_q;
    logic [DW-1:0]     rdata_q;
    logic [IDX_W-1:0]  aw_idx_q;
    logic [DW-1:0]     w_data_q;
    logic [NB-1:0]     w_strb_q;
    logic [N_REGS-1:0] wr_pulse_d, wr_pulse_q;
    logic              aw_hs, w_hs, ar_hs, wr_legal;
    logic [IDX_W-1:0]  ar_idx;
    logic [DW-1:0]     rd_src [N_SLOTS];
    logic              unused_bits;

    assign aw_hs    = if_s_axi4_lite.awvalid & awready_q;
    assign w_hs     = if_s_axi4_lite.wvalid & wready_q;
    assign ar_hs    = if_s_axi4_lite.arvalid & arready_q;
    assign ar_idx   = if_s_axi4_lite.araddr[ADDR_LSB +: IDX_W];
    assign wr_legal = VALID_EXT[aw_idx_q] & ~RO_EXT[aw_idx_q];

    assign unused_bits = ^{if_s_axi4_lite.awaddr, if_s_axi4_lite.araddr, i_sts_regs};

    for (genvar i = 0; i < N_SLOTS; i++) begin : g_slot
        if (i >= N_REGS) begin : g_unmapped
            assign rd_src[i] = '0;
        end else if (RO_MASK[i]) begin : g_ro
            assign rd_src[i]                 = i_sts_regs[i*DW +: DW];
            assign o_ctrl_regs[i*DW +: DW]   = '0;
            assign wr_pulse_d[i]             = 1'b0;
        end else begin : g_rw
            logic          wr_en;
            logic [DW-1:0] reg_q;

            assign wr_en = (w_state_q == W_COMMIT) && (aw_idx_q == IDX_W'(i));

            always_ff @(posedge i_clk or posedge i_async_rst) begin
                if (i_async_rst) begin
                    reg_q <= RST_VAL[i*DW +: DW];
                end else if (wr_en) begin
                    for (int b = 0; b < NB; b++) begin
                        if (w_strb_q[b]) begin
                            reg_q[b*8 +: 8] <= w_data_q[b*8 +: 8];
                        end
                    end
                end
            end

            assign rd_src[i]               = reg_q;
            assign o_ctrl_regs[i*DW +: DW] = reg_q;
            assign wr_pulse_d[i]           = wr_en;
        end
    end

    always_comb begin
        w_state_d = w_state_q;
        bresp_d   = bresp_q;
        unique case (w_state_q)
            W_IDLE: begin
                if (aw_hs && w_hs) begin
                    w_state_d = W_COMMIT;
                end else if (aw_hs) begin
                    w_state_d = W_HAVE_ADDR;
                end else if (w_hs) begin
                    w_state_d = W_HAVE_DATA;
                end
            end
            W_HAVE_ADDR: if (w_hs)  w_state_d = W_COMMIT;
            W_HAVE_DATA: if (aw_hs) w_state_d = W_COMMIT;
            W_COMMIT: begin
                w_state_d = W_RESP;
                bresp_d   = wr_legal ? RESP_OKAY : RESP_SLVERR;
            end
            W_RESP:  if (if_s_axi4_lite.bready) w_state_d = W_IDLE;
            default: w_state_d = W_IDLE;
        endcase
    end

    // Ready/valid are registered from the next state so they follow the FSM without a comb path.
    always_ff @(posedge i_clk or posedge i_async_rst) begin
        if (i_async_rst) begin
            w_state_q  <= W_IDLE;
            awready_q  <= 1'b0;
            wready_q   <= 1'b0;
            bvalid_q   <= 1'b0;
            bresp_q    <= RESP_OKAY;
            aw_idx_q   <= '0;
            w_data_q   <= '0;
            w_strb_q   <= '0;
            wr_pulse_q <= '0;
        end else begin
            w_state_q  <= w_state_d;
            awready_q  <= (w_state_d == W_IDLE) || (w_state_d == W_HAVE_DATA);
            wready_q   <= (w_state_d == W_IDLE) || (w_state_d == W_HAVE_ADDR);
            bvalid_q   <= (w_state_d == W_RESP);
            bresp_q    <= bresp_d;
            wr_pulse_q <= wr_pulse_d;
            if (aw_hs) begin
                aw_idx_q <= if_s_axi4_lite.awaddr[ADDR_LSB +: IDX_W];
            end
            if (w_hs) begin
                w_data_q <= if_s_axi4_lite.wdata;
                w_strb_q <= if_s_axi4_lite.wstrb;
            end
        end
    end

    always_comb begin
        r_state_d = r_state_q;
        unique case (r_state_q)
            R_IDLE:  if (ar_hs) r_state_d = R_RESP;
            R_RESP:  if (if_s_axi4_lite.rready) r_state_d = R_IDLE;
            default: r_state_d = R_IDLE;
        endcase
    end

    // Read data is captured on the AR edge, so a same-cycle commit is seen as its old value.
    always_ff @(posedge i_clk or posedge i_async_rst) begin
        if (i_async_rst) begin
            r_state_q <= R_IDLE;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            rresp_q   <= RESP_OKAY;
        end else begin
            r_state_q <= r_state_d;
            arready_q <= (r_state_d == R_IDLE);
            rvalid_q  <= (r_state_d == R_RESP);
            if (ar_hs) begin
                rdata_q <= rd_src[ar_idx];
                rresp_q <= VALID_EXT[ar_idx] ? RESP_OKAY : RESP_SLVERR;
            end
        end
    end

    assign if_s_axi4_lite.awready = awready_q;
    assign if_s_axi4_lite.wready  = wready_q;
    assign if_s_axi4_lite.bvalid  = bvalid_q;
    assign if_s_axi4_lite.bresp   = bresp_q;
    assign if_s_axi4_lite.arready = arready_q;
    assign if_s_axi4_lite.rvalid  = rvalid_q;
    assign if_s_axi4_lite.rdata   = rdata_q;
    assign if_s_axi4_lite.rresp   = rresp_q;
    assign o_wr_pulse             = wr_pulse_q;
endmodule
